// File: rtl/bullet_ctrl.sv
// Single-bullet controller: launches on fire, steps vertically every STEP_DIV frame ticks,
// retires on hit or screen exit, and addresses the 6x6 bullet sprite ROM during the raster scan.
module bullet_ctrl #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int SIZE     = 6,
    parameter int SPEED    = 4,
    parameter int STEP_DIV = 2,
    parameter int DIR      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [2:0] spr_x,
    output logic [2:0] spr_y,
    output logic       spr_en,
    input  logic       spr_data,
    output logic       pixel_on,
    output logic       busy,
    output logic [9:0] bul_x,
    output logic [9:0] bul_y
);

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } state_t;

    localparam int               CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]    STEP_LAST = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0]    STEP_ONE  = CW'(1);
    localparam logic [10:0]      SPEED_W   = 11'(SPEED);
    localparam logic [9:0]       SPEED_N   = 10'(SPEED);
    localparam logic [10:0]      Y_LIMIT   = 11'(V_RES - SIZE);
    localparam logic [10:0]      SIZE_W    = 11'(SIZE);

    if (STEP_DIV < 1 || SIZE < 1 || SIZE > 8 || H_RES < SIZE || V_RES < SIZE) begin : g_param_check
        $error("bullet_ctrl: invalid parameter set");
    end

    state_t          state_q, state_d;
    logic [9:0]      bul_x_q, bul_x_d;
    logic [9:0]      bul_y_q, bul_y_d;
    logic [CW-1:0]   step_cnt_q, step_cnt_d;
    logic            pixel_on_q;

    logic [10:0]     y_ext_s;
    logic [10:0]     y_down_s;
    logic            exit_s;
    logic [9:0]      y_moved_s;

    logic [10:0]     x_ext_s;
    logic [10:0]     px_ext_s;
    logic [10:0]     py_ext_s;
    logic            in_win_s;

    // Candidate next position and screen-exit test for a movement step (11-bit, no wrap).
    always_comb begin
        y_ext_s  = {1'b0, bul_y_q};
        y_down_s = y_ext_s + SPEED_W;
        if (DIR == 0) begin
            exit_s    = (y_ext_s < SPEED_W);
            y_moved_s = bul_y_q - SPEED_N;
        end else begin
            exit_s    = (y_down_s > Y_LIMIT);
            y_moved_s = y_down_s[9:0];
        end
    end

    // Flight FSM next state: hit beats a coincident step, fire only honoured when idle.
    always_comb begin
        state_d    = state_q;
        bul_x_d    = bul_x_q;
        bul_y_d    = bul_y_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    bul_x_d    = start_x;
                    bul_y_d    = start_y;
                    step_cnt_d = '0;
                    state_d    = FLY;
                end else begin
                    state_d = IDLE;
                end
            end
            FLY: begin
                if (hit) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = '0;
                        if (exit_s) begin
                            state_d = IDLE;
                        end else begin
                            bul_y_d = y_moved_s;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + STEP_ONE;
                    end
                end else begin
                    state_d = FLY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, position and step-divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bul_x_q    <= 10'd0;
            bul_y_q    <= 10'd0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bul_x_q    <= bul_x_d;
            bul_y_q    <= bul_y_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Sprite window decode; the low 3 bits of the offset equal the difference of the low 3 bits.
    always_comb begin
        x_ext_s  = {1'b0, bul_x_q};
        px_ext_s = {1'b0, pix_x};
        py_ext_s = {1'b0, pix_y};
        in_win_s = (state_q == FLY) &&
                   (px_ext_s >= x_ext_s) && (px_ext_s < x_ext_s + SIZE_W) &&
                   (py_ext_s >= y_ext_s) && (py_ext_s < y_ext_s + SIZE_W);
        if (in_win_s) begin
            spr_x = pix_x[2:0] - bul_x_q[2:0];
            spr_y = pix_y[2:0] - bul_y_q[2:0];
        end else begin
            spr_x = 3'd0;
            spr_y = 3'd0;
        end
        spr_en = in_win_s;
    end

    // Pixel output register: one cycle behind the raster coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on_q <= 1'b0;
        end else begin
            pixel_on_q <= spr_en & spr_data;
        end
    end

    assign pixel_on = pixel_on_q;
    assign busy     = (state_q == FLY);
    assign bul_x    = bul_x_q;
    assign bul_y    = bul_y_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: an upward (DIR=0) and a downward (DIR=1) instance share stimulus.
module tb_bullet_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fire;
    logic [9:0] start_x, start_y;
    logic       frame_tick;
    logic       hit;
    logic [9:0] pix_x, pix_y;

    logic [2:0] spr_x_u, spr_y_u, spr_x_d, spr_y_d;
    logic       spr_en_u, spr_en_d, spr_data_u, spr_data_d;
    logic       pixel_on_u, pixel_on_d, busy_u, busy_d;
    logic [9:0] bul_x_u, bul_y_u, bul_x_d, bul_y_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [5:0] rom_row(input logic [2:0] y);
        case (y)
            3'd0:    rom_row = 6'b001100;
            3'd1:    rom_row = 6'b011110;
            3'd2:    rom_row = 6'b111111;
            3'd3:    rom_row = 6'b111111;
            3'd4:    rom_row = 6'b011110;
            3'd5:    rom_row = 6'b001100;
            default: rom_row = 6'b000000;
        endcase
    endfunction

    function automatic logic rom_bit(input logic en, input logic [2:0] y, input logic [2:0] x);
        logic [5:0] row;
        row = rom_row(y);
        rom_bit = en && (x < 3'd6) ? row[x] : 1'b0;
    endfunction

    assign spr_data_u = rom_bit(spr_en_u, spr_y_u, spr_x_u);
    assign spr_data_d = rom_bit(spr_en_d, spr_y_d, spr_x_d);

    bullet_ctrl #(.DIR(0)) u_up (
        .clk(clk), .rst_n(rst_n), .fire(fire), .start_x(start_x), .start_y(start_y),
        .frame_tick(frame_tick), .hit(hit), .pix_x(pix_x), .pix_y(pix_y),
        .spr_x(spr_x_u), .spr_y(spr_y_u), .spr_en(spr_en_u), .spr_data(spr_data_u),
        .pixel_on(pixel_on_u), .busy(busy_u), .bul_x(bul_x_u), .bul_y(bul_y_u)
    );

    bullet_ctrl #(.DIR(1)) u_dn (
        .clk(clk), .rst_n(rst_n), .fire(fire), .start_x(start_x), .start_y(start_y),
        .frame_tick(frame_tick), .hit(hit), .pix_x(pix_x), .pix_y(pix_y),
        .spr_x(spr_x_d), .spr_y(spr_y_d), .spr_en(spr_en_d), .spr_data(spr_data_d),
        .pixel_on(pixel_on_d), .busy(busy_d), .bul_x(bul_x_d), .bul_y(bul_y_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fire = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        start_x = 10'd0; start_y = 10'd0; pix_x = 10'd1000; pix_y = 10'd1000;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic launch(input logic [9:0] sx, input logic [9:0] sy);
        start_x = sx; start_y = sy; fire = 1'b1;
        tick();
        fire = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy_u !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_u); end
        checks++; if (pixel_on_u !== 1'b0) begin errors++; $display("FAIL reset_pixel got %0b want 0", pixel_on_u); end
        checks++; if (bul_x_u !== 10'd0 || bul_y_u !== 10'd0) begin errors++; $display("FAIL reset_pos got (%0d,%0d) want (0,0)", bul_x_u, bul_y_u); end
        checks++; if (spr_en_u !== 1'b0) begin errors++; $display("FAIL reset_spr_en got %0b want 0", spr_en_u); end
    endtask

    task automatic test_fire_step();
        do_reset();
        launch(10'd100, 10'd200);
        checks++; if (busy_u !== 1'b1 || bul_y_u !== 10'd200) begin errors++; $display("FAIL fire_launch got busy=%0b y=%0d want busy=1 y=200", busy_u, bul_y_u); end
        ftick();
        checks++; if (bul_y_u !== 10'd200) begin errors++; $display("FAIL step_div_hold got %0d want 200", bul_y_u); end
        ftick();
        checks++; if (bul_y_u !== 10'd196) begin errors++; $display("FAIL step_2 got %0d want 196", bul_y_u); end
        repeat (4) ftick();
        checks++; if (bul_y_u !== 10'd188) begin errors++; $display("FAIL step_6 got %0d want 188", bul_y_u); end
        checks++; if (bul_x_u !== 10'd100 || busy_u !== 1'b1) begin errors++; $display("FAIL x_hold got x=%0d busy=%0b want x=100 busy=1", bul_x_u, busy_u); end
    endtask

    task automatic test_top_exit();
        do_reset();
        launch(10'd10, 10'd5);
        ftick(); ftick();
        checks++; if (bul_y_u !== 10'd1 || busy_u !== 1'b1) begin errors++; $display("FAIL top_near got y=%0d busy=%0b want y=1 busy=1", bul_y_u, busy_u); end
        ftick(); ftick();
        checks++; if (busy_u !== 1'b0 || bul_y_u !== 10'd1) begin errors++; $display("FAIL top_exit got busy=%0b y=%0d want busy=0 y=1", busy_u, bul_y_u); end
    endtask

    task automatic test_hit_priority();
        do_reset();
        launch(10'd100, 10'd104);
        ftick(); ftick(); ftick();
        launch(10'd50, 10'd50);
        checks++; if (bul_x_u !== 10'd100 || bul_y_u !== 10'd100 || busy_u !== 1'b1) begin errors++; $display("FAIL fire_in_fly got (%0d,%0d) busy=%0b want (100,100) busy=1", bul_x_u, bul_y_u, busy_u); end
        hit = 1'b1; frame_tick = 1'b1;
        tick();
        hit = 1'b0; frame_tick = 1'b0;
        checks++; if (busy_u !== 1'b0 || bul_y_u !== 10'd100) begin errors++; $display("FAIL hit_priority got busy=%0b y=%0d want busy=0 y=100", busy_u, bul_y_u); end
        hit = 1'b1;
        ftick(); ftick();
        hit = 1'b0;
        checks++; if (busy_u !== 1'b0 || bul_y_u !== 10'd100) begin errors++; $display("FAIL idle_hold got busy=%0b y=%0d want busy=0 y=100", busy_u, bul_y_u); end
    endtask

    task automatic test_raster();
        logic [5:0] row0;
        logic       want_pix;
        do_reset();
        launch(10'd100, 10'd200);
        pix_y = 10'd202;
        for (int x = 98; x <= 107; x++) begin
            pix_x = 10'(x);
            #1;
            if (x >= 100 && x <= 105) begin
                checks++; if (spr_en_u !== 1'b1 || spr_x_u !== 3'(x - 100) || spr_y_u !== 3'd2) begin errors++; $display("FAIL win_in x=%0d got en=%0b sx=%0d sy=%0d want en=1 sx=%0d sy=2", x, spr_en_u, spr_x_u, spr_y_u, x - 100); end
            end else begin
                checks++; if (spr_en_u !== 1'b0 || spr_x_u !== 3'd0 || spr_y_u !== 3'd0) begin errors++; $display("FAIL win_out x=%0d got en=%0b sx=%0d sy=%0d want 0", x, spr_en_u, spr_x_u, spr_y_u); end
            end
            want_pix = (x >= 100 && x <= 105);
            tick();
            checks++; if (pixel_on_u !== want_pix) begin errors++; $display("FAIL pix_row2 x=%0d got %0b want %0b", x, pixel_on_u, want_pix); end
        end
        row0 = 6'b001100;
        pix_y = 10'd200;
        for (int x = 0; x < 6; x++) begin
            pix_x = 10'(100 + x);
            tick();
            checks++; if (pixel_on_u !== row0[x]) begin errors++; $display("FAIL pix_row0 col=%0d got %0b want %0b", x, pixel_on_u, row0[x]); end
        end
        pix_x = 10'd102; pix_y = 10'd206;
        #1;
        checks++; if (spr_en_u !== 1'b0) begin errors++; $display("FAIL win_below got %0b want 0", spr_en_u); end
        pix_x = 10'd1000; pix_y = 10'd1000;
    endtask

    task automatic test_dir_down();
        do_reset();
        launch(10'd10, 10'd468);
        ftick(); ftick();
        checks++; if (bul_y_d !== 10'd472 || busy_d !== 1'b1) begin errors++; $display("FAIL down_step got y=%0d busy=%0b want y=472 busy=1", bul_y_d, busy_d); end
        ftick(); ftick();
        checks++; if (busy_d !== 1'b0 || bul_y_d !== 10'd472) begin errors++; $display("FAIL down_exit got busy=%0b y=%0d want busy=0 y=472", busy_d, bul_y_d); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        launch(10'd100, 10'd200);
        pix_x = 10'd100; pix_y = 10'd202;
        tick();
        checks++; if (pixel_on_u !== 1'b1 || busy_u !== 1'b1) begin errors++; $display("FAIL pre_reset got pix=%0b busy=%0b want 1,1", pixel_on_u, busy_u); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy_u !== 1'b0 || pixel_on_u !== 1'b0) begin errors++; $display("FAIL async_reset got busy=%0b pix=%0b want 0,0", busy_u, pixel_on_u); end
        checks++; if (bul_x_u !== 10'd0 || bul_y_u !== 10'd0) begin errors++; $display("FAIL async_pos got (%0d,%0d) want (0,0)", bul_x_u, bul_y_u); end
        tick();
        rst_n = 1'b1;
        ftick(); ftick(); ftick();
        checks++; if (busy_u !== 1'b0 || bul_y_u !== 10'd0 || pixel_on_u !== 1'b0) begin errors++; $display("FAIL post_reset got busy=%0b y=%0d pix=%0b want 0,0,0", busy_u, bul_y_u, pixel_on_u); end
        pix_x = 10'd1000; pix_y = 10'd1000;
    endtask

    initial begin
        test_reset();
        test_fire_step();
        test_top_exit();
        test_hit_priority();
        test_raster();
        test_dir_down();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bullet_ctrl.md
Name: bullet_ctrl

Overview:
Owns one bullet in flight: accepts a fire request, holds and advances the bullet position once per STEP_DIV frame ticks, and retires the bullet on hit or screen exit. During the raster scan it drives the coordinate/enable side of the 6x6 bullet sprite ROM and registers the returned pixel bit for the video mixer. One instance per shooter (player, enemy); it sits between the game logic and the pixel pipeline.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
SIZE, 6, sprite edge length in pixels; fixed to match sprite ROM
SPEED, 4, pixels moved per step
STEP_DIV, 2, frame ticks per movement step (>=1)
DIR, 0, travel direction: 0 = up (y decreasing), 1 = down (y increasing)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fire  in  1  one-cycle fire request
start_x  in  10  launch x (top-left of sprite)
start_y  in  10  launch y (top-left of sprite)
frame_tick  in  1  one-cycle pulse per frame (vsync start)
hit  in  1  collision reported by game logic; kills bullet
pix_x  in  10  current raster x
pix_y  in  10  current raster y
spr_x  out  3  column index to sprite ROM
spr_y  out  3  row index to sprite ROM
spr_en  out  1  sprite ROM enable
spr_data  in  1  sprite ROM pixel (0 when spr_en=0)
pixel_on  out  1  registered bullet pixel for the mixer
busy  out  1  bullet in flight
bul_x  out  10  current bullet x (top-left)
bul_y  out  10  current bullet y (top-left)

Behaviour:
- Reset (async, rst_n=0): state IDLE, bul_x=0, bul_y=0, step_cnt=0, busy=0, pixel_on=0. Reset mid-flight drops the bullet immediately.
- States: IDLE, FLY. busy=1 iff state==FLY (registered).
- IDLE: fire=1 -> load bul_x<=start_x, bul_y<=start_y, step_cnt<=0, go FLY next cycle. hit ignored in IDLE. start values are not range-checked.
- FLY: fire ignored (one bullet at a time, no queueing).
- FLY, hit=1 -> IDLE next cycle; hit has priority over a coincident frame_tick step. bul_x/bul_y hold last values.
- FLY, frame_tick=1, no hit: if step_cnt==STEP_DIV-1 then step_cnt<=0 and move; else step_cnt++.
- Move, DIR=0: if bul_y < SPEED -> IDLE (exit top), else bul_y <= bul_y-SPEED.
- Move, DIR=1: if bul_y+SPEED > V_RES-SIZE -> IDLE (exit bottom), else bul_y <= bul_y+SPEED. Compare in 11 bits, no wrap.
- bul_x never changes in flight.
- Sprite addressing (combinational): in_win = (state==FLY) && pix_x>=bul_x && pix_x<bul_x+SIZE && pix_y>=bul_y && pix_y<bul_y+SIZE, sums in 11 bits. spr_en=in_win; spr_x=(pix_x-bul_x)[2:0], spr_y=(pix_y-bul_y)[2:0] when in_win, else 0. Indices always 0..5 when spr_en=1.
- pixel_on <= spr_en & spr_data every cycle: exactly 1-cycle latency from pix_x/pix_y.
- Position changes take effect on the next pixel cycle; intended update point is frame_tick (blanking), so no tearing mid-frame.

Test Plan:
- Reset: assert rst_n=0 mid-flight (busy=1, bul_y=200) -> busy=0, pixel_on=0, bul_x=bul_y=0 asynchronously; no movement after release until fire.
- Fire & step, DIR=0, STEP_DIV=2, SPEED=4: fire with start (100,200) -> busy=1 next cycle; after 2 frame_ticks bul_y=196; after 6 ticks bul_y=188; bul_x stays 100.
- Top exit: start_y=5, DIR=0 -> after 2 ticks bul_y=1; after 2 more (1<4) busy=0.
- Hit priority: FLY at bul_y=100, step_cnt=1, hit and frame_tick same cycle -> busy=0 next cycle, bul_y stays 100; fire in FLY before that -> ignored, position unchanged.
- Raster window: bullet at (100,200), scan pix_y=202, pix_x 98..107 -> spr_en=1 only for x=100..105 with spr_x=0..5, spr_y=2; pixel_on equals ROM row 2 (all ones) one cycle later, 0 outside window.
- DIR=1, V_RES=480: start_y=468 -> after one step bul_y=472 (472+4>474 not yet checked); next step 476>474 -> busy=0.
